// File: rtl/decoder_2_4_pkg.sv
// Shared types and the select-to-one-hot decode used by decoder_2_4.
// Optional feature macro: DECODER_2_4_VALID_EN (adds out_valid on the top).
package decoder_2_4_pkg;

   localparam int SEL_W = 2;
   localparam int OUT_W = 4;

   typedef logic [SEL_W-1:0] sel_t;
   typedef logic [OUT_W-1:0] onehot_t;

   localparam onehot_t IDLE_HI = 4'b0000;
   localparam onehot_t IDLE_LO = 4'b1111;

   // Unknown selects fall to the idle pattern so synthesis never builds a multi-hot path.
   function automatic onehot_t decode(input sel_t sel);
      onehot_t res;
      case (sel)
         2'b00:   res = 4'b0001;
         2'b01:   res = 4'b0010;
         2'b10:   res = 4'b0100;
         2'b11:   res = 4'b1000;
         default: res = IDLE_HI;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/decoder_2_4_core.sv
// Purely combinational active-high 2-to-4 decode with enable gating.
// Polarity, registering and reset are applied by the decoder_2_4 top.
module decoder_2_4_core
   import decoder_2_4_pkg::*;
(
   input  logic [1:0] sel,
   input  logic       enable,
   output logic [3:0] onehot
);

   always_comb begin
      onehot = IDLE_HI;
      if (enable) begin
         onehot = decode(sel);
      end
   end

endmodule

// File: rtl/decoder_2_4.sv
// Registered 2-to-4 one-hot/one-cold decoder with enable and synchronous reset.
// Define DECODER_2_4_VALID_EN to add the out_valid output tracking enable.
module decoder_2_4
   import decoder_2_4_pkg::*;
#(
   parameter int OUT_ACTIVE_HIGH = 1,
   parameter int REG_OUT         = 1
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       in1,
   input  logic       in2,
   input  logic       enable,
   output logic [3:0] out
`ifdef DECODER_2_4_VALID_EN
   ,
   output logic       out_valid
`endif
);

   localparam onehot_t IDLE = (OUT_ACTIVE_HIGH != 0) ? IDLE_HI : IDLE_LO;

   onehot_t core_out;
   onehot_t pol_out;

   decoder_2_4_core u_core (
      .sel    ({in1, in2}),
      .enable (enable),
      .onehot (core_out)
   );

   // One-cold mode inverts everything, the idle pattern included.
   assign pol_out = (OUT_ACTIVE_HIGH != 0) ? core_out : ~core_out;

   generate
      if (REG_OUT != 0) begin : g_reg
         onehot_t out_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               out_q <= IDLE;
            end else begin
               out_q <= pol_out;
            end
         end
         assign out = out_q;
`ifdef DECODER_2_4_VALID_EN
         logic valid_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               valid_q <= 1'b0;
            end else begin
               valid_q <= enable;
            end
         end
         assign out_valid = valid_q;
`endif
      end else begin : g_comb
         // Combinational mode: reset has no effect on the decode.
         assign out = pol_out;
`ifdef DECODER_2_4_VALID_EN
         assign out_valid = enable;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_decoder_2_4.sv
// Self-checking bench for decoder_2_4: registered high/low polarity and combinational builds.
// Expected values are queued at drive time and popped one edge later.
module tb_decoder_2_4;

   logic       clk;
   logic       rst;
   logic       in1;
   logic       in2;
   logic       enable;
   logic [3:0] out_hi;
   logic [3:0] out_lo;
   logic [3:0] out_cb;
   logic       v_hi;
   logic       v_lo;
   logic       v_cb;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Packed entry: {valid, active-high out, active-low out}
   logic [8:0] exp_q[$];

   decoder_2_4 #(.OUT_ACTIVE_HIGH(1), .REG_OUT(1)) dut (
      .clk(clk), .rst(rst), .in1(in1), .in2(in2), .enable(enable), .out(out_hi)
`ifdef DECODER_2_4_VALID_EN
      , .out_valid(v_hi)
`endif
   );

   decoder_2_4 #(.OUT_ACTIVE_HIGH(0), .REG_OUT(1)) dut_lo (
      .clk(clk), .rst(rst), .in1(in1), .in2(in2), .enable(enable), .out(out_lo)
`ifdef DECODER_2_4_VALID_EN
      , .out_valid(v_lo)
`endif
   );

   decoder_2_4 #(.OUT_ACTIVE_HIGH(1), .REG_OUT(0)) dut_cb (
      .clk(clk), .rst(rst), .in1(in1), .in2(in2), .enable(enable), .out(out_cb)
`ifdef DECODER_2_4_VALID_EN
      , .out_valid(v_cb)
`endif
   );

`ifndef DECODER_2_4_VALID_EN
   assign v_hi = 1'b0;
   assign v_lo = 1'b0;
   assign v_cb = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference decode from the truth table.
   function automatic logic [3:0] ref_hi(input logic r, input logic s1, input logic s0, input logic e);
      logic [3:0] tbl [4];
      tbl[0] = 4'b0001;
      tbl[1] = 4'b0010;
      tbl[2] = 4'b0100;
      tbl[3] = 4'b1000;
      if (r || !e) return 4'b0000;
      return tbl[{s1, s0}];
   endfunction

   task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
   endtask

   // Drive one cycle (called at negedge), check combinational build, then registered outputs after the edge.
   task automatic step(input string tag, input logic r, input logic s1, input logic s0, input logic e);
      logic [8:0] ent;
      logic [3:0] hi;
      rst = r; in1 = s1; in2 = s0; enable = e;
      hi = ref_hi(r, s1, s0, e);
      exp_q.push_back({(!r && e), hi, ~hi});
      #1;
      check4({tag, "_comb"}, out_cb, ref_hi(1'b0, s1, s0, e));
`ifdef DECODER_2_4_VALID_EN
      check1({tag, "_comb_valid"}, v_cb, e);
`endif
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check1({tag, "_queue_empty"}, 1'b1, 1'b0);
      end else begin
         ent = exp_q.pop_front();
         check4({tag, "_hi"}, out_hi, ent[7:4]);
         check4({tag, "_lo"}, out_lo, ent[3:0]);
         check1({tag, "_onehot"}, ($countones(out_hi) <= 1), 1'b1);
`ifdef DECODER_2_4_VALID_EN
         check1({tag, "_valid"}, v_hi, ent[8]);
         check1({tag, "_valid_lo"}, v_lo, ent[8]);
`endif
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; in1 = 1'b0; in2 = 1'b0; enable = 1'b0;
      @(negedge clk);

      // Reset held with enable and sel=11, then released.
      step("rst0", 1, 1, 1, 1);
      step("rst1", 1, 1, 1, 1);
      step("rel", 0, 1, 1, 1);

      // Full sweep while enabled.
      step("sw00", 0, 0, 0, 1);
      step("sw01", 0, 0, 1, 1);
      step("sw10", 0, 1, 0, 1);
      step("sw11", 0, 1, 1, 1);

      // Disabled for every select.
      step("dis00", 0, 0, 0, 0);
      step("dis01", 0, 0, 1, 0);
      step("dis10", 0, 1, 0, 0);
      step("dis11", 0, 1, 1, 0);

      // Enable toggle at sel=10.
      step("tog_on", 0, 1, 0, 1);
      step("tog_off", 0, 1, 0, 0);

      // Mid-operation reset pulse on a steady sel=01 stream.
      step("mid0", 0, 0, 1, 1);
      step("mid_rst", 1, 0, 1, 1);
      step("mid1", 0, 0, 1, 1);

      // Random traffic with occasional reset.
      for (int i = 0; i < 1000; i++) begin
         step("rand", ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      end

      check1("queue_drained", (exp_q.size() == 0), 1'b1);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/decoder_2_4.md
Name: decoder_2_4

Overview:
- Registered 2-to-4 one-hot decoder with active-high enable.
- Select = {in1, in2}, with in1 as the MSB. When enabled, exactly one output bit is driven active; when disabled, none is.
- Used as a small address/chip-select decode leaf. The output is registered so downstream logic sees glitch-free selects.

Parameters:
- OUT_ACTIVE_HIGH, 1, polarity: 1 = selected bit is 1 and others 0; 0 = selected bit is 0 and others 1 (idle all-ones).
- REG_OUT, 1, 1 = output registered (1-cycle latency); 0 = combinational decode, reset ignored for out.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  synchronous reset, active-high
- in1  input  1  select MSB
- in2  input  1  select LSB
- enable  input  1  decode enable, active-high
- out  output  4  one-hot (or one-cold) decoded select

Behaviour:
- Synchronous, active-high reset: when rst is sampled high at a rising clk, out becomes the idle value. Idle is 4'b0000 when OUT_ACTIVE_HIGH=1 and 4'b1111 when OUT_ACTIVE_HIGH=0.
- Decode table, active-high, enable=1:
  - {in1,in2}=00 -> 0001
  - 01 -> 0010
  - 10 -> 0100
  - 11 -> 1000
- In general out[{in1,in2}] = active and all other bits inactive.
- enable=0 -> out = idle value, regardless of in1/in2.
- OUT_ACTIVE_HIGH=0: out is the bitwise inverse of the active-high result, including the idle value.
- REG_OUT=1: out is updated at the rising clk edge from the inputs sampled at that edge (latency 1 cycle). out is stable between edges; input glitches between edges have no effect.
- REG_OUT=0: out follows the inputs combinationally.
- rst has priority over enable and select. rst asserted mid-operation forces idle at the next edge. Decode resumes on the first edge with rst low.
- X/Z on any input must not yield a multi-hot output in synthesis. The default case branch drives the idle value.
- Invariant: at most one active bit ever, exactly one when enabled and not in reset.

Optional Feature:
- Macro DECODER_2_4_VALID_EN.
- Defined: adds output port out_valid (1 bit). It is registered alongside out, equals enable when not in reset, and resets to 0. It is combinational from enable when REG_OUT=0.
- Not defined: the port is absent; behaviour is otherwise identical.

Decomposition:
- Package decoder_2_4_pkg holds:
  - SEL_W=2 and OUT_W=4 constants
  - sel_t typedef (logic [1:0])
  - onehot_t typedef (logic [3:0])
  - IDLE_HI (4'b0000) and IDLE_LO (4'b1111) constants
  - decode function sel -> onehot_t
- One sub-module, decoder_2_4_core: purely combinational decode of sel and enable into active-high one-hot.
- Top level applies polarity, optional register, reset, and the optional valid output.

Test Plan:
- Reset: hold rst=1 for 2 cycles with enable=1 and sel=11 -> out=0000 (out_valid=0 if enabled). Release rst -> next edge out=1000.
- Full sweep: enable=1, sel 00,01,10,11 on consecutive cycles -> out 0001, 0010, 0100, 1000, each 1 cycle after the input is applied.
- Disable: enable=0 for all four sel values -> out=0000 every cycle. Toggle enable 1->0 with sel=10 -> out goes 0100 then 0000.
- Mid-op reset: stream sel=01, enable=1, and assert rst for 1 cycle -> out 0010, then 0000, then 0010.
- Polarity: OUT_ACTIVE_HIGH=0, sel=10, enable=1 -> out=1011; enable=0 or rst -> out=1111.
- Random: 1000 random cycles of in1/in2/enable -> out matches a 1-cycle-delayed reference model, and $countones(out) ≤ 1 always (active-high).
